// File: rtl/i2c_target_if.sv
// Bus-side and write-port signals of the I2C write-only register target.
// The slave modport is the target's view; master is the parent/bench.
interface i2c_target_if;
  logic       scl;
  logic       sda_in;
  logic       sda_oe;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  modport master (
    output scl, sda_in,
    input  sda_oe, wr_stb, wr_addr, wr_data, busy
  );

  modport slave (
    input  scl, sda_in,
    output sda_oe, wr_stb, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/i2c_target.sv
// I2C write-only register target: address byte, pointer byte, then
// data bytes written to an auto-incrementing pointer.
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h10
) (
  input  logic        clk,
  input  logic        rst,
  i2c_target_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_REG,
    S_REG_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  state_t     state;
  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_d;
  logic       sda_d;
  logic       scl_s;
  logic       sda_s;
  logic [2:0] cnt;
  logic [6:0] sr;
  logic [7:0] ptr;
  logic [7:0] nxt;
  logic       start;
  logic       stop;
  logic       rise;
  logic       fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], bus.scl};
      sda_ff <= {sda_ff[0], bus.sda_in};
      scl_d  <= scl_ff[1];
      sda_d  <= sda_ff[1];
    end
  end

  assign scl_s = scl_ff[1];
  assign sda_s = sda_ff[1];
  assign start = scl_s & scl_d & sda_d & ~sda_s;
  assign stop  = scl_s & scl_d & ~sda_d & sda_s;
  assign rise  = scl_s & ~scl_d;
  assign fall  = ~scl_s & scl_d;
  assign nxt   = {sr, sda_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 3'd0;
      sr          <= 7'd0;
      ptr         <= 8'h00;
      bus.sda_oe  <= 1'b0;
      bus.wr_stb  <= 1'b0;
      bus.wr_addr <= 8'h00;
      bus.wr_data <= 8'h00;
      bus.busy    <= 1'b0;
    end else begin
      bus.wr_stb <= 1'b0;
      if (bus.wr_stb)
        ptr <= ptr + 8'd1;
      // Bus conditions win over any SCL edge seen in the same clk
      if (start) begin
        state      <= S_ADDR;
        cnt        <= 3'd0;
        bus.sda_oe <= 1'b0;
        bus.busy   <= 1'b0;
      end else if (stop) begin
        state      <= S_IDLE;
        cnt        <= 3'd0;
        bus.sda_oe <= 1'b0;
        bus.busy   <= 1'b0;
      end else begin
        unique case (state)
          S_ADDR, S_REG, S_DATA: begin
            if (rise) begin
              sr  <= nxt[6:0];
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                unique case (state)
                  S_ADDR: begin
                    if (nxt[7:1] == ADDR && !nxt[0]) begin
                      state    <= S_ADDR_ACK;
                      bus.busy <= 1'b1;
                    end else begin
                      state <= S_IGNORE;
                    end
                  end
                  S_REG: begin
                    ptr   <= nxt;
                    state <= S_REG_ACK;
                  end
                  default: begin
                    bus.wr_stb  <= 1'b1;
                    bus.wr_data <= nxt;
                    bus.wr_addr <= ptr;
                    state       <= S_DATA_ACK;
                  end
                endcase
              end
            end
          end
          S_ADDR_ACK, S_REG_ACK, S_DATA_ACK: begin
            // First fall opens the ACK slot, second fall closes it
            if (fall) begin
              if (!bus.sda_oe) begin
                bus.sda_oe <= 1'b1;
              end else begin
                bus.sda_oe <= 1'b0;
                cnt        <= 3'd0;
                state      <= (state == S_ADDR_ACK) ? S_REG : S_DATA;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: vector table, corner sequences
// and randomized transactions against a transaction-level model.
module tb_i2c_target;

  localparam int Q = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  i2c_target_if bus ();

  assign bus.scl    = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  i2c_target #(.ADDR(7'h10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] wrq [$];
  int   oe_cnt   = 0;
  int   long_cnt = 0;
  logic prev_stb = 1'b0;

  always @(negedge clk) begin
    if (bus.wr_stb)
      wrq.push_back({bus.wr_addr, bus.wr_data});
    if (bus.wr_stb && prev_stb)
      long_cnt++;
    prev_stb = bus.wr_stb;
    if (bus.sda_oe)
      oe_cnt++;
  end

  typedef struct {
    int          n;
    logic [7:0]  b [6];
    int          exp_ack;
    int          exp_nwr;
    logic [15:0] exp_wr [3];
    bit          no_oe;
    bit          exp_busy;
  } vec_t;

  vec_t vt [4];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nb);
    for (int i = 7; i > 7 - nb; i--) begin
      m_sda = b[i]; tick(Q);
      m_scl = 1'b1; tick(2 * Q);
      m_scl = 1'b0; tick(Q);
    end
  endtask

  task automatic ack_bit(output logic ack);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    ack = ~bus.sda_in;
    tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic run_txn(input logic [7:0] b [6], input int n,
                         output int nack);
    logic a;
    nack = 0;
    i2c_start;
    for (int i = 0; i < n; i++) begin
      send_bits(b[i], 8);
      ack_bit(a);
      if (a) nack++;
    end
  endtask

  task automatic check_writes(input string nm, input int base,
                              input logic [15:0] exp [$]);
    check({nm, "_nwr"}, wrq.size() - base, exp.size());
    for (int i = 0; i < exp.size() && base + i < wrq.size(); i++)
      check({nm, "_wr"}, wrq[base + i], exp[i]);
  endtask

  // Transaction-level reference: who acks and which writes land where
  function automatic void model(input logic [7:0] b [6], input int n,
                                input logic [7:0] p_in,
                                output int exp_ack,
                                output logic [7:0] p_out,
                                output logic [15:0] exp [$]);
    int p;
    bit hit;
    hit = (b[0] == 8'h20);
    exp_ack = hit ? n : 0;
    exp = {};
    p = p_in;
    if (hit && n >= 2) begin
      p = b[1];
      for (int i = 2; i < n; i++) begin
        exp.push_back({p[7:0], b[i]});
        p = (p + 1) % 256;
      end
    end
    p_out = p[7:0];
  endfunction

  initial begin
    int nack;
    int base;
    int oe0;
    logic a;
    logic [7:0] bb [6];
    logic [15:0] eq [$];
    logic [7:0] ptr;
    int ea;
    bit stp;

    vt[0].n = 3;
    vt[0].b = '{8'h20, 8'h05, 8'hA5, 8'h00, 8'h00, 8'h00};
    vt[0].exp_ack = 3; vt[0].exp_nwr = 1;
    vt[0].exp_wr = '{16'h05A5, 16'h0, 16'h0};
    vt[0].no_oe = 0; vt[0].exp_busy = 1;
    vt[1].n = 5;
    vt[1].b = '{8'h20, 8'hFE, 8'h11, 8'h22, 8'h33, 8'h00};
    vt[1].exp_ack = 5; vt[1].exp_nwr = 3;
    vt[1].exp_wr = '{16'hFE11, 16'hFF22, 16'h0033};
    vt[1].no_oe = 0; vt[1].exp_busy = 1;
    vt[2].n = 2;
    vt[2].b = '{8'h22, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[2].exp_ack = 0; vt[2].exp_nwr = 0;
    vt[2].exp_wr = '{16'h0, 16'h0, 16'h0};
    vt[2].no_oe = 1; vt[2].exp_busy = 0;
    vt[3].n = 3;
    vt[3].b = '{8'h21, 8'h05, 8'hA5, 8'h00, 8'h00, 8'h00};
    vt[3].exp_ack = 0; vt[3].exp_nwr = 0;
    vt[3].exp_wr = '{16'h0, 16'h0, 16'h0};
    vt[3].no_oe = 1; vt[3].exp_busy = 0;

    rst = 1'b1;
    tick(3);
    check("rst_oe", bus.sda_oe, 0);
    check("rst_stb", bus.wr_stb, 0);
    check("rst_addr", bus.wr_addr, 0);
    check("rst_data", bus.wr_data, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    tick(4);

    for (int v = 0; v < 4; v++) begin
      base = wrq.size();
      oe0 = oe_cnt;
      run_txn(vt[v].b, vt[v].n, nack);
      check($sformatf("v%0d_ack", v), nack, vt[v].exp_ack);
      check($sformatf("v%0d_busy", v), bus.busy, vt[v].exp_busy);
      i2c_stop;
      tick(4);
      check($sformatf("v%0d_busy_stop", v), bus.busy, 0);
      eq = {};
      for (int i = 0; i < vt[v].exp_nwr; i++)
        eq.push_back(vt[v].exp_wr[i]);
      check_writes($sformatf("v%0d", v), base, eq);
      if (vt[v].no_oe)
        check($sformatf("v%0d_no_oe", v), oe_cnt - oe0, 0);
    end

    // Partial data byte cut short by STOP, then a clean write
    base = wrq.size();
    i2c_start;
    send_bits(8'h20, 8); ack_bit(a);
    send_bits(8'h05, 8); ack_bit(a);
    send_bits(8'hA5, 4);
    i2c_stop;
    tick(4);
    check("partial_busy", bus.busy, 0);
    bb = '{8'h20, 8'h07, 8'h3C, 8'h00, 8'h00, 8'h00};
    run_txn(bb, 3, nack);
    check("after_partial_ack", nack, 3);
    i2c_stop;
    tick(4);
    check_writes("partial", base, '{16'h073C});

    // Reset during the 9th clock of the address ACK
    base = wrq.size();
    i2c_start;
    send_bits(8'h20, 8);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    check("ack_before_rst", bus.sda_oe, 1);
    rst = 1'b1; tick(1);
    rst = 1'b0;
    check("oe_after_rst", bus.sda_oe, 0);
    check("busy_after_rst", bus.busy, 0);
    tick(Q);
    m_scl = 1'b0; tick(Q);
    oe0 = oe_cnt;
    send_bits(8'h05, 8); ack_bit(a);
    check("post_rst_nack1", a, 0);
    send_bits(8'h3C, 8); ack_bit(a);
    check("post_rst_nack2", a, 0);
    check("post_rst_no_oe", oe_cnt - oe0, 0);
    i2c_stop;
    tick(4);
    check_writes("post_rst", base, '{});
    base = wrq.size();
    bb = '{8'h20, 8'h09, 8'h5A, 8'h00, 8'h00, 8'h00};
    run_txn(bb, 3, nack);
    check("fresh_ack", nack, 3);
    i2c_stop;
    tick(4);
    check_writes("fresh", base, '{16'h095A});

    // Randomized transactions, some chained by repeated START
    ptr = 8'h09;
    for (int t = 0; t < 24; t++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int i = 0; i < 6; i++)
        bb[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0)
        bb[0] = 8'h20;
      stp = (t == 23) || ($urandom_range(0, 2) != 0);
      model(bb, n, ptr, ea, ptr, eq);
      base = wrq.size();
      oe0 = oe_cnt;
      run_txn(bb, n, nack);
      check($sformatf("r%0d_ack", t), nack, ea);
      check($sformatf("r%0d_busy", t), bus.busy, bb[0] == 8'h20);
      if (bb[0] != 8'h20)
        check($sformatf("r%0d_no_oe", t), oe_cnt - oe0, 0);
      if (stp) begin
        i2c_stop;
        tick(4);
        check($sformatf("r%0d_busy_stop", t), bus.busy, 0);
      end
      check_writes($sformatf("r%0d", t), base, eq);
    end

    check("stb_width", long_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter ADDR, default 7'h10, 7-bit target address matched against the address byte.
REQ-002 clk  input  1  system clock, at least 8x the SCL frequency; single clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 scl  input  1  raw bus SCL, asynchronous to clk.
REQ-005 sda_in  input  1  raw bus SDA, asynchronous to clk.
REQ-006 sda_oe  output  1  1 = pull SDA low; open-drain tristating is done by the parent module.
REQ-007 wr_stb  output  1  one-clk pulse when a data byte is complete.
REQ-008 wr_addr  output  8  register pointer for the current write; valid with wr_stb.
REQ-009 wr_data  output  8  received data byte; valid with wr_stb.
REQ-010 busy  output  1  high between an addressed START and the next STOP or abort.

Function
REQ-011 scl and sda_in shall pass through 2-FF synchronizers; all logic shall use the synchronized values and their 1-clk-delayed copies.
REQ-012 START = synced SDA falls while synced SCL is high; STOP = synced SDA rises while synced SCL is high.
REQ-013 Bits shall be sampled MSB-first on the detected SCL rising edge; sda_oe shall change only on the detected SCL falling edge, or on START/STOP.
REQ-014 States shall be IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE.
REQ-015 IDLE: on START, clear the bit counter and go to ADDR; all other activity is ignored.
REQ-016 ADDR: after 8 bits, if byte[7:1]==ADDR and byte[0]==0, go to ADDR_ACK and set busy.
REQ-017 ADDR: otherwise (address mismatch or read request), go to IGNORE without driving sda_oe.
REQ-018 ACK states: sda_oe shall be set at the SCL falling edge after the 8th bit and cleared at the next SCL falling edge (end of the 9th clock); then proceed.
REQ-019 ADDR_ACK -> REG; REG collects 8 bits into the pointer, then -> REG_ACK -> DATA.
REQ-020 DATA: on the SCL rising edge that samples the 8th bit, wr_stb shall pulse for exactly 1 clk on the following clk cycle, with wr_data = byte and wr_addr = pointer; then -> DATA_ACK -> DATA.
REQ-021 The pointer shall increment by 1 in the clk after wr_stb and wrap 8'hFF -> 8'h00.
REQ-022 STOP in any state shall give next state IDLE, sda_oe=0, busy=0; a partial byte is discarded with no wr_stb.
REQ-023 Repeated START in any state shall give next state ADDR with the bit counter cleared; the pointer is retained and busy is cleared until the next address match.
REQ-024 IGNORE shall leave only on START or STOP.
REQ-025 If START/STOP and an SCL edge are detected in the same clk, START/STOP shall take priority.
REQ-026 The block shall never drive SDA outside the ACK states.

Reset
REQ-027 On rst: state=IDLE, sda_oe=0, wr_stb=0, wr_addr=8'h00, wr_data=8'h00, busy=0, bit counter=0, synchronizer flops=1.
REQ-028 rst asserted mid-transfer shall abort immediately, with no wr_stb, and the block shall wait for a fresh START.

Verification
REQ-029 START, 0x20, 0x05, 0xA5, STOP -> ACK on all 3 bytes; one wr_stb with wr_addr=0x05, wr_data=0xA5; busy low after STOP.
REQ-030 START, 0x20, 0xFE, 0x11, 0x22, 0x33, STOP -> wr_stb 3 times with addr/data 0xFE/0x11, 0xFF/0x22, 0x00/0x33.
REQ-031 START, 0x22, 0x05, STOP -> sda_oe never asserted, no wr_stb.
REQ-032 START, 0x21 (read) -> NACK, no wr_stb, IGNORE until STOP.
REQ-033 START, 0x20, 0x05, 4 bits of 0xA5, STOP -> no wr_stb; a following START, 0x20, 0x07, 0x3C, STOP -> wr_addr=0x07, wr_data=0x3C.
REQ-034 rst pulsed during the 9th clock of ADDR_ACK -> sda_oe=0 on the next clk; following SDA/SCL activity ignored until a new START.
